uart_cmd_parser: RTL and testbench

- Sits directly downstream of the UART byte receiver.
- Consumes its byte stream (data, valid strobe, framing-error strobe) and assembles host command frames for the TPU control path.
- Frame format: SYNC (0xA5), OPCODE, LEN, LEN payload bytes, CHK. CHK is the XOR of OPCODE, LEN and all payload bytes.
- Emits a command-start event, a per-byte payload stream and a command-done event with pass/fail status. Provides inter-byte timeout recovery and error counters.

---
 rtl/uart_cmd_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Host command frame parser: SYNC, OPCODE, LEN, LEN payload bytes, CHK (XOR of OPCODE..payload).
// Streams payload bytes out, reports frame completion/status and keeps a saturating error count.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned MAX_PAYLOAD  = 64,
    parameter int unsigned TIMEOUT_CLKS = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       framing_error,
    output logic       cmd_start,
    output logic [7:0] cmd_opcode,
    output logic [7:0] cmd_len,
    output logic       pay_valid,
    output logic [7:0] pay_data,
    output logic [7:0] pay_index,
    output logic       cmd_done,
    output logic       cmd_ok,
    output logic       err_timeout,
    output logic       err_frame,
    output logic       err_len,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned    TW     = $clog2(TIMEOUT_CLKS);
    localparam logic [TW-1:0]  TLast  = TW'(TIMEOUT_CLKS - 1);
    localparam logic [8:0]     MaxLen = 9'(MAX_PAYLOAD);

    typedef enum logic [2:0] {
        StHunt,
        StOpcode,
        StLen,
        StPayload,
        StCheck
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    op_q, op_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cmd_start_q, cmd_start_d;
    logic [7:0]    cmd_opcode_q, cmd_opcode_d;
    logic [7:0]    cmd_len_q, cmd_len_d;
    logic          pay_valid_q, pay_valid_d;
    logic [7:0]    pay_data_q, pay_data_d;
    logic [7:0]    pay_index_q, pay_index_d;
    logic          cmd_done_q, cmd_done_d;
    logic          cmd_ok_q, cmd_ok_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_frame_q, err_frame_d;
    logic          err_len_q, err_len_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          busy_q, busy_d;
    logic          err_inc;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        idx_d         = idx_q;
        op_d          = op_q;
        cmd_start_d   = 1'b0;
        cmd_opcode_d  = cmd_opcode_q;
        cmd_len_d     = cmd_len_q;
        pay_valid_d   = 1'b0;
        pay_data_d    = pay_data_q;
        pay_index_d   = pay_index_q;
        cmd_done_d    = 1'b0;
        cmd_ok_d      = cmd_ok_q;
        err_timeout_d = 1'b0;
        err_frame_d   = 1'b0;
        err_len_d     = 1'b0;
        err_inc       = 1'b0;

        if (rx_valid || framing_error) begin
            tcnt_d = '0;
        end else if (state_q != StHunt) begin
            tcnt_d = tcnt_q + 1'b1;
        end else begin
            tcnt_d = '0;
        end

        // A framing error always wins over a coincident byte, which is dropped.
        if (framing_error) begin
            err_inc = 1'b1;
            if (state_q != StHunt) begin
                err_frame_d = 1'b1;
                state_d     = StHunt;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (rx_data == SYNC_BYTE) state_d = StOpcode;
                end
                StOpcode: begin
                    op_d    = rx_data;
                    acc_d   = rx_data;
                    state_d = StLen;
                end
                StLen: begin
                    acc_d = acc_q ^ rx_data;
                    if ({1'b0, rx_data} > MaxLen) begin
                        err_len_d = 1'b1;
                        err_inc   = 1'b1;
                        state_d   = StHunt;
                    end else begin
                        // Published header only changes once a header is accepted.
                        cmd_start_d  = 1'b1;
                        cmd_opcode_d = op_q;
                        cmd_len_d    = rx_data;
                        idx_d        = 8'd0;
                        state_d      = (rx_data == 8'd0) ? StCheck : StPayload;
                    end
                end
                StPayload: begin
                    pay_valid_d = 1'b1;
                    pay_data_d  = rx_data;
                    pay_index_d = idx_q;
                    acc_d       = acc_q ^ rx_data;
                    idx_d       = idx_q + 8'd1;
                    if (idx_q == cmd_len_q - 8'd1) state_d = StCheck;
                end
                StCheck: begin
                    cmd_done_d = 1'b1;
                    cmd_ok_d   = (rx_data == acc_q);
                    err_inc    = (rx_data != acc_q);
                    state_d    = StHunt;
                end
                default: state_d = StHunt;
            endcase
        end else if ((state_q != StHunt) && (tcnt_q == TLast)) begin
            err_timeout_d = 1'b1;
            err_inc       = 1'b1;
            state_d       = StHunt;
            tcnt_d        = '0;
        end

        err_count_d = (err_inc && (err_count_q != 8'hFF)) ? err_count_q + 8'd1 : err_count_q;
        busy_d      = (state_d != StHunt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StHunt;
            acc_q         <= 8'd0;
            idx_q         <= 8'd0;
            op_q          <= 8'd0;
            tcnt_q        <= '0;
            cmd_start_q   <= 1'b0;
            cmd_opcode_q  <= 8'd0;
            cmd_len_q     <= 8'd0;
            pay_valid_q   <= 1'b0;
            pay_data_q    <= 8'd0;
            pay_index_q   <= 8'd0;
            cmd_done_q    <= 1'b0;
            cmd_ok_q      <= 1'b0;
            err_timeout_q <= 1'b0;
            err_frame_q   <= 1'b0;
            err_len_q     <= 1'b0;
            err_count_q   <= 8'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            idx_q         <= idx_d;
            op_q          <= op_d;
            tcnt_q        <= tcnt_d;
            cmd_start_q   <= cmd_start_d;
            cmd_opcode_q  <= cmd_opcode_d;
            cmd_len_q     <= cmd_len_d;
            pay_valid_q   <= pay_valid_d;
            pay_data_q    <= pay_data_d;
            pay_index_q   <= pay_index_d;
            cmd_done_q    <= cmd_done_d;
            cmd_ok_q      <= cmd_ok_d;
            err_timeout_q <= err_timeout_d;
            err_frame_q   <= err_frame_d;
            err_len_q     <= err_len_d;
            err_count_q   <= err_count_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_start   = cmd_start_q;
    assign cmd_opcode  = cmd_opcode_q;
    assign cmd_len     = cmd_len_q;
    assign pay_valid   = pay_valid_q;
    assign pay_data    = pay_data_q;
    assign pay_index   = pay_index_q;
    assign cmd_done    = cmd_done_q;
    assign cmd_ok      = cmd_ok_q;
    assign err_timeout = err_timeout_q;
    assign err_frame   = err_frame_q;
    assign err_len     = err_len_q;
    assign err_count   = err_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected output events are queued as bytes are driven
// and matched in order against the pulses the DUT produces.
module tb_uart_cmd_parser;

    localparam int unsigned TO = 100;

    localparam logic [2:0] KStart = 3'd1;
    localparam logic [2:0] KPay   = 3'd2;
    localparam logic [2:0] KDone  = 3'd3;
    localparam logic [2:0] KTo    = 3'd4;
    localparam logic [2:0] KFr    = 3'd5;
    localparam logic [2:0] KLen   = 3'd6;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       cmd_start;
    logic [7:0] cmd_opcode;
    logic [7:0] cmd_len;
    logic       pay_valid;
    logic [7:0] pay_data;
    logic [7:0] pay_index;
    logic       cmd_done;
    logic       cmd_ok;
    logic       err_timeout;
    logic       err_frame;
    logic       err_len;
    logic [7:0] err_count;
    logic       busy;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    uart_cmd_parser #(
        .SYNC_BYTE   (8'hA5),
        .MAX_PAYLOAD (64),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .cmd_start    (cmd_start),
        .cmd_opcode   (cmd_opcode),
        .cmd_len      (cmd_len),
        .pay_valid    (pay_valid),
        .pay_data     (pay_data),
        .pay_index    (pay_index),
        .cmd_done     (cmd_done),
        .cmd_ok       (cmd_ok),
        .err_timeout  (err_timeout),
        .err_frame    (err_frame),
        .err_len      (err_len),
        .err_count    (err_count),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] k, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        return e;
    endfunction

    // Scoreboard: every output pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        ev_t obs;
        ev_t e;
        #1;
        if (cmd_start || pay_valid || cmd_done || err_timeout || err_frame || err_len) begin
            if (cmd_start)        obs = mk(KStart, cmd_opcode, cmd_len);
            else if (pay_valid)   obs = mk(KPay, pay_data, pay_index);
            else if (cmd_done)    obs = mk(KDone, {7'd0, cmd_ok}, 8'd0);
            else if (err_timeout) obs = mk(KTo, 8'd0, 8'd0);
            else if (err_frame)   obs = mk(KFr, 8'd0, 8'd0);
            else                  obs = mk(KLen, 8'd0, 8'd0);
            chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("event", 64'(obs), 64'(e));
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic ferr(input logic with_byte, input logic [7:0] b);
        framing_error = 1'b1;
        rx_valid      = with_byte;
        rx_data       = b;
        @(negedge clk);
        framing_error = 1'b0;
        rx_valid      = 1'b0;
    endtask

    task automatic send_seq_frame(input logic [7:0] op, input logic [7:0] len,
                                  input logic [7:0] seed);
        logic [7:0] acc;
        logic [7:0] b;
        acc = op ^ len;
        exp_q.push_back(mk(KStart, op, len));
        send(8'hA5);
        send(op);
        send(len);
        for (int i = 0; i < int'(len); i++) begin
            b   = seed + 8'(i);
            acc = acc ^ b;
            exp_q.push_back(mk(KPay, b, 8'(i)));
            send(b);
        end
        exp_q.push_back(mk(KDone, 8'd1, 8'd0));
        send(acc);
    endtask

    function automatic logic [47:0] all_outs();
        return {cmd_start, cmd_opcode, cmd_len, pay_valid, pay_data, pay_index, cmd_done,
                cmd_ok, err_timeout, err_frame, err_len, err_count, busy};
    endfunction

    initial begin
        rst_n         = 1'b0;
        rx_data       = 8'd0;
        rx_valid      = 1'b0;
        framing_error = 1'b0;
        #1;
        chk("reset_outputs", 64'(all_outs()), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Nominal frame
        exp_q.push_back(mk(KStart, 8'h10, 8'h02));
        exp_q.push_back(mk(KPay, 8'h11, 8'h00));
        exp_q.push_back(mk(KPay, 8'h22, 8'h01));
        exp_q.push_back(mk(KDone, 8'h01, 8'h00));
        send(8'hA5);
        chk("busy_after_sync", 64'(busy), 64'd1);
        send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
        chk("nom_ok", 64'(cmd_ok), 64'd1);
        chk("nom_opcode", 64'(cmd_opcode), 64'h10);
        chk("nom_len", 64'(cmd_len), 64'h02);
        chk("nom_errcnt", 64'(err_count), 64'd0);
        chk("nom_busy", 64'(busy), 64'd0);

        // Bad checksum
        exp_q.push_back(mk(KStart, 8'h10, 8'h02));
        exp_q.push_back(mk(KPay, 8'h11, 8'h00));
        exp_q.push_back(mk(KPay, 8'h22, 8'h01));
        exp_q.push_back(mk(KDone, 8'h00, 8'h00));
        send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h20);
        chk("badchk_errcnt", 64'(err_count), 64'd1);

        // Zero-length frame goes straight to the checksum byte
        exp_q.push_back(mk(KStart, 8'h07, 8'h00));
        exp_q.push_back(mk(KDone, 8'h01, 8'h00));
        send(8'hA5); send(8'h07); send(8'h00); send(8'h07);
        chk("zero_len", 64'(cmd_len), 64'd0);
        chk("zero_errcnt", 64'(err_count), 64'd1);

        // LEN one above the limit, then garbage in HUNT
        exp_q.push_back(mk(KLen, 8'h00, 8'h00));
        send(8'hA5); send(8'h01); send(8'h41);
        chk("len_busy", 64'(busy), 64'd0);
        chk("len_errcnt", 64'(err_count), 64'd2);
        send(8'h00); send(8'hFF); send(8'hA4);
        chk("garbage_busy", 64'(busy), 64'd0);
        send_seq_frame(8'h03, 8'h01, 8'h5A);
        send_seq_frame(8'h3C, 8'd64, 8'h80);
        chk("maxlen_len", 64'(cmd_len), 64'd64);
        chk("maxlen_idx", 64'(pay_index), 64'd63);
        chk("maxlen_errcnt", 64'(err_count), 64'd2);

        // Inter-byte timeout fires exactly TO clocks after the last byte
        send(8'hA5); send(8'h10);
        repeat (TO - 1) @(negedge clk);
        chk("to_early", 64'({err_timeout, busy}), 64'b01);
        exp_q.push_back(mk(KTo, 8'h00, 8'h00));
        @(negedge clk);
        chk("to_fire", 64'({err_timeout, busy}), 64'b10);
        chk("to_errcnt", 64'(err_count), 64'd3);

        // Byte on the expiry cycle is accepted
        send(8'hA5); send(8'h10);
        repeat (TO - 1) @(negedge clk);
        exp_q.push_back(mk(KStart, 8'h10, 8'h00));
        exp_q.push_back(mk(KDone, 8'h01, 8'h00));
        send(8'h00); send(8'h10);
        chk("to_suppr_errcnt", 64'(err_count), 64'd3);
        repeat (TO + 20) @(negedge clk);
        chk("hunt_no_to", 64'(err_count), 64'd3);

        // Framing error mid-payload
        exp_q.push_back(mk(KStart, 8'h10, 8'h03));
        exp_q.push_back(mk(KPay, 8'h11, 8'h00));
        exp_q.push_back(mk(KFr, 8'h00, 8'h00));
        send(8'hA5); send(8'h10); send(8'h03); send(8'h11);
        ferr(1'b0, 8'h00);
        chk("fe_busy", 64'(busy), 64'd0);
        chk("fe_errcnt", 64'(err_count), 64'd4);

        // Framing error with a coincident byte drops the byte
        exp_q.push_back(mk(KStart, 8'h20, 8'h02));
        exp_q.push_back(mk(KPay, 8'h33, 8'h00));
        exp_q.push_back(mk(KFr, 8'h00, 8'h00));
        send(8'hA5); send(8'h20); send(8'h02); send(8'h33);
        ferr(1'b1, 8'h44);
        chk("fe_coinc_data", 64'({pay_data, pay_index}), 64'h3300);
        chk("fe_coinc_errcnt", 64'(err_count), 64'd5);
        ferr(1'b1, 8'hA5);
        chk("fe_hunt_sync_drop", 64'(busy), 64'd0);
        chk("fe_hunt_errcnt", 64'(err_count), 64'd6);

        repeat (300) ferr(1'b0, 8'h00);
        chk("errcnt_sat", 64'(err_count), 64'd255);

        // Asynchronous reset mid-payload
        exp_q.push_back(mk(KStart, 8'h44, 8'h03));
        exp_q.push_back(mk(KPay, 8'h01, 8'h00));
        exp_q.push_back(mk(KPay, 8'h02, 8'h01));
        send(8'hA5); send(8'h44); send(8'h03); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", 64'(all_outs()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_seq_frame(8'h55, 8'h03, 8'h10);
        chk("post_reset_ok", 64'(cmd_ok), 64'd1);
        chk("post_reset_errcnt", 64'(err_count), 64'd0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
